// File: rtl/mouse_tracker_pkg.sv
// Shared constants, FSM encoding and packet header layout for the PS/2 mouse tracker.
package mouse_tracker_pkg;

    // Host-to-mouse command and mouse acknowledge byte
    localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
    localparam logic [7:0] RSP_ACK       = 8'hFA;

    // Bit 3 of the first packet byte is always 1; used to find packet alignment
    localparam int B1_SYNC_BIT = 3;

    typedef enum logic [2:0] {
        ST_SEND     = 3'd0,
        ST_WAIT_TX  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_PKT1     = 3'd3,
        ST_PKT2     = 3'd4,
        ST_PKT3     = 3'd5,
        ST_UPDATE   = 3'd6
    } state_t;

    // Fields of packet byte 1 that are kept (the sync bit is not needed after alignment)
    typedef struct packed {
        logic       yovf;
        logic       xovf;
        logic       ysign;
        logic       xsign;
        logic [2:0] btn;    // {middle, right, left}
    } pkt_hdr_t;

    // Unpack byte 1 into the header struct
    function automatic pkt_hdr_t unpack_hdr(input logic [7:0] b);
        pkt_hdr_t h;
        h.yovf  = b[7];
        h.xovf  = b[6];
        h.ysign = b[5];
        h.xsign = b[4];
        h.btn   = b[2:0];
        return h;
    endfunction

    // Build the 9-bit signed movement; an overflowed axis contributes no movement
    function automatic logic signed [8:0] make_delta(input logic sign, input logic [7:0] low,
                                                     input logic ovf);
        logic signed [8:0] d;
        d = ovf ? 9'sd0 : $signed({sign, low});
        return d;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Adds a 9-bit signed delta (optionally negated) to a 10-bit position and clamps to [0, LIMIT-1].
module sat_add #(
    parameter int LIMIT  = 640,
    parameter bit NEGATE = 1'b0
) (
    input  logic [9:0]        base,
    input  logic signed [8:0] delta,
    output logic [9:0]        result
);

    // Negation happens at 12 bits so that -(-256) = +256 is representable
    localparam logic signed [11:0] MAX_S = 12'(LIMIT - 1);
    localparam logic [9:0]         MAX_U = 10'(LIMIT - 1);

    logic signed [11:0] delta_ext;
    logic signed [11:0] sum;

    // Sign-extend, optionally negate, add and clamp
    always_comb begin
        delta_ext = {{3{delta[8]}}, delta};
        if (NEGATE) begin
            delta_ext = -delta_ext;
        end
        sum = $signed({2'b00, base}) + delta_ext;
        if (sum < 12'sd0) begin
            result = 10'd0;
        end else if (sum > MAX_S) begin
            result = MAX_U;
        end else begin
            result = sum[9:0];
        end
    end

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 mouse tracker: enables streaming, assembles 3-byte packets and keeps a clamped cursor.
module mouse_tracker
    import mouse_tracker_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int ACK_TIMEOUT = 2_500_000,
    parameter int PKT_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       tx_done_tick,
    output logic       wr_ps2,
    output logic [7:0] din,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic [2:0] btnm,
    output logic       update_tick,
    output logic       ready
);

    localparam int TMAX = (ACK_TIMEOUT > PKT_TIMEOUT) ? ACK_TIMEOUT : PKT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] PKT_LAST = TW'(PKT_TIMEOUT - 1);

    state_t         state_reg, state_next;
    logic [TW-1:0]  timer_reg, timer_next;
    pkt_hdr_t       hdr_reg, hdr_next;
    logic [7:0]     dx_reg, dx_next;
    logic [7:0]     dy_reg, dy_next;
    logic           wr_ps2_reg, wr_ps2_next;
    logic           update_tick_reg, update_tick_next;
    logic           ready_reg, ready_next;
    logic [2:0]     btnm_reg, btnm_next;
    logic [9:0]     pos_reg  [2];
    logic [9:0]     pos_next [2];
    logic [9:0]     pos_sat  [2];
    logic signed [8:0] delta [2];

    assign delta[0] = make_delta(hdr_reg.xsign, dx_reg, hdr_reg.xovf);
    assign delta[1] = make_delta(hdr_reg.ysign, dy_reg, hdr_reg.yovf);

    // Axis 0 is x (adds delta), axis 1 is y (PS/2 up is positive, screen up is negative)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            sat_add #(
                .LIMIT  ((gi == 0) ? H_RES : V_RES),
                .NEGATE (gi == 1)
            ) u_sat (
                .base   (pos_reg[gi]),
                .delta  (delta[gi]),
                .result (pos_sat[gi])
            );
        end
    endgenerate

    // State register with the shared timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_SEND;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state logic; the timer restarts on every state change and every received byte
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_SEND:     state_next = ST_WAIT_TX;
            ST_WAIT_TX:  if (tx_done_tick) state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (rx_done_tick && rx_data == RSP_ACK) state_next = ST_PKT1;
                else if (!rx_done_tick && timer_reg == ACK_LAST) state_next = ST_SEND;
            end
            ST_PKT1:     if (rx_done_tick && rx_data[B1_SYNC_BIT]) state_next = ST_PKT2;
            ST_PKT2: begin
                if (rx_done_tick) state_next = ST_PKT3;
                else if (timer_reg == PKT_LAST) state_next = ST_PKT1;
            end
            ST_PKT3: begin
                if (rx_done_tick) state_next = ST_UPDATE;
                else if (timer_reg == PKT_LAST) state_next = ST_PKT1;
            end
            ST_UPDATE:   state_next = ST_PKT1;
            default:     state_next = ST_SEND;
        endcase

        if (state_next != state_reg || rx_done_tick) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + 1'b1;
        end
    end

    // Output/datapath next values derived from the current state
    always_comb begin
        hdr_next         = hdr_reg;
        dx_next          = dx_reg;
        dy_next          = dy_reg;
        btnm_next        = btnm_reg;
        pos_next[0]      = pos_reg[0];
        pos_next[1]      = pos_reg[1];
        wr_ps2_next      = (state_reg == ST_SEND);
        update_tick_next = (state_reg == ST_UPDATE);
        ready_next       = ready_reg;
        unique case (state_reg)
            ST_WAIT_ACK: if (rx_done_tick && rx_data == RSP_ACK) ready_next = 1'b1;
            ST_PKT1:     if (rx_done_tick && rx_data[B1_SYNC_BIT]) hdr_next = unpack_hdr(rx_data);
            ST_PKT2:     if (rx_done_tick) dx_next = rx_data;
            ST_PKT3:     if (rx_done_tick) dy_next = rx_data;
            ST_UPDATE: begin
                pos_next[0] = pos_sat[0];
                pos_next[1] = pos_sat[1];
                btnm_next   = hdr_reg.btn;
            end
            default: ;
        endcase
    end

    // Registered outputs and packet byte latches
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_reg         <= '0;
            dx_reg          <= '0;
            dy_reg          <= '0;
            btnm_reg        <= '0;
            pos_reg[0]      <= 10'(X_INIT);
            pos_reg[1]      <= 10'(Y_INIT);
            wr_ps2_reg      <= 1'b0;
            update_tick_reg <= 1'b0;
            ready_reg       <= 1'b0;
        end else begin
            hdr_reg         <= hdr_next;
            dx_reg          <= dx_next;
            dy_reg          <= dy_next;
            btnm_reg        <= btnm_next;
            pos_reg[0]      <= pos_next[0];
            pos_reg[1]      <= pos_next[1];
            wr_ps2_reg      <= wr_ps2_next;
            update_tick_reg <= update_tick_next;
            ready_reg       <= ready_next;
        end
    end

    assign wr_ps2      = wr_ps2_reg;
    assign din         = CMD_STREAM_EN;
    assign mouse_x     = pos_reg[0];
    assign mouse_y     = pos_reg[1];
    assign btnm        = btnm_reg;
    assign update_tick = update_tick_reg;
    assign ready       = ready_reg;

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed testbench for mouse_tracker with shortened timeouts.
module tb_mouse_tracker;

    localparam int ACK_TO = 200;
    localparam int PKT_TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic       wr_ps2;
    logic [7:0] din;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic [2:0] btnm;
    logic       update_tick;
    logic       ready;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    int upd_count = 0;

    mouse_tracker #(
        .H_RES(640), .V_RES(480), .X_INIT(320), .Y_INIT(240),
        .ACK_TIMEOUT(ACK_TO), .PKT_TIMEOUT(PKT_TO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
        .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .din(din),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .btnm(btnm),
        .update_tick(update_tick), .ready(ready)
    );

    always #5 clk = ~clk;

    // Count strobes on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst && wr_ps2) wr_count++;
        if (!rst && update_tick) upd_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic tx_done();
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (wr_ps2) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
        check({tag, "_din"}, 32'(din), 32'hF4);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_x"}, 32'(mouse_x), 32'd320);
        check({tag, "_y"}, 32'(mouse_y), 32'd240);
        check({tag, "_btn"}, 32'(btnm), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_wr"}, 32'(wr_ps2), 32'd0);
        check({tag, "_upd"}, 32'(update_tick), 32'd0);
        wr_count = 0;
        rst = 1'b0;
    endtask

    task automatic handshake(input string tag);
        wait_wr({tag, "_wr"}, 50);
        repeat (3) @(negedge clk);
        tx_done();
        repeat (2) @(negedge clk);
        rx_byte(8'hFA);
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    // Send one packet and check one-cycle update_tick timing plus new outputs
    task automatic packet(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int ex, input int ey, input int eb);
        rx_byte(b1);
        rx_byte(b2);
        rx_byte(b3);
        check({tag, "_tick_early"}, 32'(update_tick), 32'd0);
        @(negedge clk);
        check({tag, "_tick"}, 32'(update_tick), 32'd1);
        check({tag, "_x"}, 32'(mouse_x), 32'(ex));
        check({tag, "_y"}, 32'(mouse_y), 32'(ey));
        check({tag, "_btn"}, 32'(btnm), 32'(eb));
        @(negedge clk);
        check({tag, "_tick_end"}, 32'(update_tick), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;

        // 1: reset state, single F4, ACK after an ignored non-ACK byte
        do_reset("rst1");
        wait_wr("t1_wr", 50);
        repeat (3) @(negedge clk);
        tx_done();
        repeat (3) @(negedge clk);
        check("t1_ready_before_ack", 32'(ready), 32'd0);
        rx_byte(8'h33);
        check("t1_ready_non_ack", 32'(ready), 32'd0);
        rx_byte(8'hFA);
        check("t1_ready", 32'(ready), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_wr_count", 32'(wr_count), 32'd1);

        // 2: ACK timeout triggers a resend
        do_reset("rst2");
        wait_wr("t2_wr1", 50);
        repeat (2) @(negedge clk);
        tx_done();
        wait_wr("t2_wr2", ACK_TO + 50);
        repeat (2) @(negedge clk);
        check("t2_wr_count", 32'(wr_count), 32'd2);
        check("t2_ready_pre", 32'(ready), 32'd0);
        tx_done();
        rx_byte(8'hFA);
        check("t2_ready", 32'(ready), 32'd1);

        // 3: basic packet
        packet("t3", 8'h09, 8'h0A, 8'h05, 330, 235, 3'b001);

        // 4: large moves and clamping at every edge
        packet("t4a", 8'h38, 8'h1A, 8'h15, 100, 470, 3'b000);
        packet("t4b", 8'h38, 8'h00, 8'h00, 0, 479, 3'b000);
        packet("t4c", 8'h08, 8'hFF, 8'hFF, 255, 224, 3'b000);
        packet("t4d", 8'h08, 8'hFF, 8'hFF, 510, 0, 3'b000);
        packet("t4e", 8'h08, 8'hFF, 8'hFF, 639, 0, 3'b000);
        packet("t4f", 8'h08, 8'hFF, 8'h00, 639, 0, 3'b000);

        // 5: stray byte resync, then overflow flag
        packet("t5a", 8'h38, 8'h11, 8'h38, 400, 200, 3'b000);
        repeat (2) @(negedge clk);
        u0 = upd_count;
        rx_byte(8'h00);
        repeat (4) @(negedge clk);
        check("t5_stray_no_upd", 32'(upd_count), 32'(u0));
        check("t5_stray_x", 32'(mouse_x), 32'd400);
        packet("t5b", 8'h08, 8'h01, 8'h01, 401, 199, 3'b000);
        packet("t5c", 8'h4E, 8'h7F, 8'h01, 401, 198, 3'b110);

        // 6: packet timeout discards partial packet
        repeat (2) @(negedge clk);
        u0 = upd_count;
        rx_byte(8'h08);
        rx_byte(8'h05);
        repeat (PKT_TO + 10) @(negedge clk);
        check("t6_timeout_no_upd", 32'(upd_count), 32'(u0));
        check("t6_timeout_x", 32'(mouse_x), 32'd401);
        packet("t6a", 8'h08, 8'h02, 8'h00, 403, 198, 3'b000);

        // 6b: reset mid-packet restores defaults and resends F4
        rx_byte(8'h09);
        rx_byte(8'h05);
        do_reset("rst3");
        wait_wr("t6_wr", 50);
        repeat (3) @(negedge clk);
        check("t6_wr_count", 32'(wr_count), 32'd1);
        check("t6_ready_after_rst", 32'(ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
